// File: rtl/lfsr_period_checker.sv
// rtl/lfsr_period_checker.sv - measures an LFSR's period from seed load to seed return
// Reports period, pass flag, rotate-XOR signature and sticky stuck/timeout/done faults.
module lfsr_period_checker #(
  parameter int NUM_BITS = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                seed_dv,
  input  logic [NUM_BITS-1:0] seed_data,
  input  logic [NUM_BITS-1:0] lfsr_data,
  input  logic                lfsr_done,
  output logic                busy,
  output logic                chk_done,
  output logic                pass,
  output logic [NUM_BITS:0]   period,
  output logic [NUM_BITS-1:0] signature,
  output logic                stuck_err,
  output logic                timeout_err,
  output logic                done_err
);

  typedef enum logic [2:0] {IDLE, ARMED, RUN, DONE, FAULT} state_t;

  localparam logic [NUM_BITS:0] MAX_PERIOD = {1'b0, {NUM_BITS{1'b1}}};
  localparam logic [NUM_BITS:0] ONE        = {{NUM_BITS{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic [NUM_BITS-1:0] prev_q, prev_d;
  logic [NUM_BITS-1:0] sig_q, sig_d;
  logic [NUM_BITS:0]   count_q, count_d;
  logic [NUM_BITS:0]   period_q, period_d;
  logic                busy_q, busy_d;
  logic                chk_done_q, chk_done_d;
  logic                pass_q, pass_d;
  logic                stuck_q, stuck_d;
  logic                tmo_q, tmo_d;
  logic                derr_q, derr_d;
  logic [NUM_BITS:0]   next_count;
  logic [NUM_BITS-1:0] sig_rot;

  assign next_count = count_q + ONE;
  assign sig_rot    = {sig_q[NUM_BITS-2:0], sig_q[NUM_BITS-1]};

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    prev_d     = prev_q;
    sig_d      = sig_q;
    count_d    = count_q;
    period_d   = period_q;
    pass_d     = pass_q;
    stuck_d    = stuck_q;
    tmo_d      = tmo_q;
    derr_d     = derr_q;
    chk_done_d = 1'b0;

    if (seed_dv) begin
      state_d  = ARMED;
      seed_d   = seed_data;
      count_d  = '0;
      sig_d    = '0;
      period_d = '0;
      pass_d   = 1'b0;
      stuck_d  = 1'b0;
      tmo_d    = 1'b0;
      derr_d   = 1'b0;
    end else if (enable) begin
      case (state_q)
        ARMED: begin
          if (lfsr_data == seed_q) begin
            prev_d  = lfsr_data;
            sig_d   = lfsr_data;
            count_d = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          // Priority: stuck, then seed return, then timeout, then accumulate.
          if (lfsr_data == prev_q) begin
            stuck_d    = 1'b1;
            period_d   = next_count;
            state_d    = FAULT;
            chk_done_d = 1'b1;
          end else if (lfsr_data == seed_q) begin
            period_d   = next_count;
            pass_d     = (next_count == MAX_PERIOD) && !derr_q && lfsr_done;
            derr_d     = derr_q | ~lfsr_done;
            state_d    = DONE;
            chk_done_d = 1'b1;
          end else if (next_count == MAX_PERIOD) begin
            tmo_d      = 1'b1;
            period_d   = next_count;
            state_d    = FAULT;
            chk_done_d = 1'b1;
          end else begin
            count_d = next_count;
            prev_d  = lfsr_data;
            sig_d   = sig_rot ^ lfsr_data;
            if (lfsr_done) begin
              derr_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ARMED) || (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      seed_q     <= '0;
      prev_q     <= '0;
      sig_q      <= '0;
      count_q    <= '0;
      period_q   <= '0;
      busy_q     <= 1'b0;
      chk_done_q <= 1'b0;
      pass_q     <= 1'b0;
      stuck_q    <= 1'b0;
      tmo_q      <= 1'b0;
      derr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      prev_q     <= prev_d;
      sig_q      <= sig_d;
      count_q    <= count_d;
      period_q   <= period_d;
      busy_q     <= busy_d;
      chk_done_q <= chk_done_d;
      pass_q     <= pass_d;
      stuck_q    <= stuck_d;
      tmo_q      <= tmo_d;
      derr_q     <= derr_d;
    end
  end

  assign busy        = busy_q;
  assign chk_done    = chk_done_q;
  assign pass        = pass_q;
  assign period      = period_q;
  assign signature   = sig_q;
  assign stuck_err   = stuck_q;
  assign timeout_err = tmo_q;
  assign done_err    = derr_q;

endmodule
